// File: rtl/dataframe_parser_pkg.sv
// Shared dataframe constants: beat IDs, header/footer field positions and error bit indices.
package dataframe_parser_pkg;

  localparam int RFDC_TDATA_WIDTH = 128;

  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;

  localparam int ID_MSB   = 127;
  localparam int ID_LSB   = 120;
  localparam int CH_MSB   = 119;
  localparam int CH_LSB   = 112;
  localparam int TS_MSB   = 111;
  localparam int TS_LSB   = 64;
  localparam int TRIG_MSB = 63;
  localparam int TRIG_LSB = 48;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  localparam int ERR_HDR_ID       = 0;
  localparam int ERR_LEN_RANGE    = 1;
  localparam int ERR_LEN_MISMATCH = 2;
  localparam int ERR_FTR_ID       = 3;
  localparam int ERR_TRUNC        = 4;
  localparam int ERR_WIDTH        = 5;

  localparam logic [15:0] DEFAULT_MAX_LEN = 16'd512;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_DATA,
    ST_FOOTER,
    ST_DROP
  } state_e;

  function automatic logic idMatches(input logic [RFDC_TDATA_WIDTH-1:0] beat,
                                     input logic [7:0] id,
                                     input logic [7:0] ch);
    return (beat[ID_MSB:ID_LSB] == id) && (beat[CH_MSB:CH_LSB] == ch);
  endfunction

endpackage

// File: rtl/dataframe_parser_if.sv
// AXI4-Stream bundle used for both the dataframe input and the ADC-beat output.
interface dataframe_parser_if;
  import dataframe_parser_pkg::*;

  logic [RFDC_TDATA_WIDTH-1:0] TDATA;
  logic                        TVALID;
  logic                        TLAST;
  logic                        TREADY;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);

endinterface

// File: rtl/dataframe_parser_axis_reg_slice.sv
// Single-entry AXI4-Stream output register: data+last held stable under back-pressure.
module axis_reg_slice
  import dataframe_parser_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [RFDC_TDATA_WIDTH-1:0] data_i,
  input  logic                        last_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  dataframe_parser_if.master          m_axis
);

  logic [RFDC_TDATA_WIDTH-1:0] data_q;
  logic                        last_q;
  logic                        valid_q;

  // Refill whenever the held beat is empty or leaving this cycle, giving full throughput.
  assign ready_o = !valid_q || m_axis.TREADY;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end

  assign m_axis.TDATA  = data_q;
  assign m_axis.TLAST  = last_q;
  assign m_axis.TVALID = valid_q;

endmodule

// File: rtl/dataframe_parser.sv
// Receive-side dataframe parser: validates header/footer framing, strips them and
// forwards ADC beats, publishing header fields, per-frame status and frame counters.
module dataframe_parser
  import dataframe_parser_pkg::*;
#(
  parameter logic [7:0] CHANNEL_ID = 8'h00
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [15:0]          MAX_TRIGGER_LENGTH,
  input  logic                 SET_CONFIG,
  dataframe_parser_if.slave    S_AXIS,
  dataframe_parser_if.master   M_AXIS,
  output logic                 HDR_VALID,
  output logic [47:0]          HDR_TIMESTAMP,
  output logic [15:0]          HDR_TRIGGER_INFO,
  output logic [15:0]          HDR_LENGTH,
  output logic                 FRAME_DONE,
  output logic                 FRAME_OK,
  output logic [ERR_WIDTH-1:0] ERROR_FLAGS,
  input  logic                 CLEAR_ERROR,
  output logic [15:0]          GOOD_FRAME_CNT,
  output logic [15:0]          BAD_FRAME_CNT
);

  state_e                state_q, state_d;
  logic [15:0]           maxLen_q, maxLen_d;
  logic [15:0]           curLen_q, curLen_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [47:0]           ts_q, ts_d;
  logic [15:0]           trig_q, trig_d;
  logic [15:0]           len_q, len_d;
  logic                  hdrValid_q, hdrValid_d;
  logic                  frameDone_q, frameDone_d;
  logic                  frameOk_q, frameOk_d;
  logic [ERR_WIDTH-1:0]  errFlags_q, errFlags_d;
  logic [15:0]           goodCnt_q, goodCnt_d;
  logic [15:0]           badCnt_q, badCnt_d;
  logic [ERR_WIDTH-1:0]  newErr;

  logic        sliceReady;
  logic        fwdValid;
  logic        fwdLast;
  logic        sReady;
  logic        sAccept;
  logic [15:0] beatLen;
  logic        lastBeat;

  assign sReady   = (state_q == ST_DATA) ? sliceReady : 1'b1;
  assign sAccept  = S_AXIS.TVALID && sReady;
  assign beatLen  = S_AXIS.TDATA[LEN_MSB:LEN_LSB];
  assign lastBeat = (cnt_q + 16'd1) == curLen_q;
  assign S_AXIS.TREADY = sReady;

  axis_reg_slice uSlice (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .data_i  (S_AXIS.TDATA),
    .last_i  (fwdLast),
    .valid_i (fwdValid),
    .ready_o (sliceReady),
    .m_axis  (M_AXIS)
  );

  always_comb begin
    state_d     = state_q;
    maxLen_d    = SET_CONFIG ? MAX_TRIGGER_LENGTH : maxLen_q;
    curLen_d    = curLen_q;
    cnt_d       = cnt_q;
    ts_d        = ts_q;
    trig_d      = trig_q;
    len_d       = len_q;
    hdrValid_d  = 1'b0;
    frameDone_d = 1'b0;
    frameOk_d   = 1'b0;
    newErr      = '0;
    fwdValid    = 1'b0;
    fwdLast     = 1'b0;

    case (state_q)
      ST_HEADER: begin
        if (sAccept) begin
          // A rejected header that also carries TLAST is a complete (bad) frame on its own.
          if (!idMatches(S_AXIS.TDATA, HEADER_ID, CHANNEL_ID)) begin
            newErr[ERR_HDR_ID] = 1'b1;
            if (S_AXIS.TLAST) frameDone_d = 1'b1;
            else              state_d     = ST_DROP;
          end else if (beatLen == 16'd0 || beatLen > maxLen_q) begin
            newErr[ERR_LEN_RANGE] = 1'b1;
            if (S_AXIS.TLAST) frameDone_d = 1'b1;
            else              state_d     = ST_DROP;
          end else if (S_AXIS.TLAST) begin
            newErr[ERR_TRUNC] = 1'b1;
            frameDone_d       = 1'b1;
          end else begin
            ts_d       = S_AXIS.TDATA[TS_MSB:TS_LSB];
            trig_d     = S_AXIS.TDATA[TRIG_MSB:TRIG_LSB];
            len_d      = beatLen;
            curLen_d   = beatLen;
            cnt_d      = 16'd0;
            hdrValid_d = 1'b1;
            state_d    = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        fwdValid = S_AXIS.TVALID;
        fwdLast  = lastBeat || S_AXIS.TLAST;
        if (sAccept) begin
          cnt_d = cnt_q + 16'd1;
          // Input TLAST inside the payload means the footer never arrives.
          if (S_AXIS.TLAST) begin
            newErr[ERR_TRUNC] = 1'b1;
            frameDone_d       = 1'b1;
            state_d           = ST_HEADER;
          end else if (lastBeat) begin
            state_d = ST_FOOTER;
          end
        end
      end

      ST_FOOTER: begin
        if (sAccept) begin
          if (!idMatches(S_AXIS.TDATA, FOOTER_ID, CHANNEL_ID)) newErr[ERR_FTR_ID] = 1'b1;
          if (beatLen != curLen_q || !S_AXIS.TLAST)           newErr[ERR_LEN_MISMATCH] = 1'b1;
          if (S_AXIS.TLAST) begin
            frameDone_d = 1'b1;
            frameOk_d   = (newErr == '0);
            state_d     = ST_HEADER;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        if (sAccept && S_AXIS.TLAST) begin
          frameDone_d = 1'b1;
          state_d     = ST_HEADER;
        end
      end

      default: state_d = ST_HEADER;
    endcase

    errFlags_d = (CLEAR_ERROR ? '0 : errFlags_q) | newErr;

    goodCnt_d = goodCnt_q;
    badCnt_d  = badCnt_q;
    if (frameDone_d) begin
      if (frameOk_d)                goodCnt_d = goodCnt_q + 16'd1;
      else if (badCnt_q != 16'hFFFF) badCnt_d = badCnt_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_HEADER;
      maxLen_q    <= DEFAULT_MAX_LEN;
      curLen_q    <= '0;
      cnt_q       <= '0;
      ts_q        <= '0;
      trig_q      <= '0;
      len_q       <= '0;
      hdrValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      frameOk_q   <= 1'b0;
      errFlags_q  <= '0;
      goodCnt_q   <= '0;
      badCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      maxLen_q    <= maxLen_d;
      curLen_q    <= curLen_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      trig_q      <= trig_d;
      len_q       <= len_d;
      hdrValid_q  <= hdrValid_d;
      frameDone_q <= frameDone_d;
      frameOk_q   <= frameOk_d;
      errFlags_q  <= errFlags_d;
      goodCnt_q   <= goodCnt_d;
      badCnt_q    <= badCnt_d;
    end
  end

  assign HDR_VALID        = hdrValid_q;
  assign HDR_TIMESTAMP    = ts_q;
  assign HDR_TRIGGER_INFO = trig_q;
  assign HDR_LENGTH       = len_q;
  assign FRAME_DONE       = frameDone_q;
  assign FRAME_OK         = frameOk_q;
  assign ERROR_FLAGS      = errFlags_q;
  assign GOOD_FRAME_CNT   = goodCnt_q;
  assign BAD_FRAME_CNT    = badCnt_q;

endmodule

// File: tb/tb_dataframe_parser.sv
// Self-checking bench for dataframe_parser: table of frame scenarios, hand-written
// config/reset/clear sequences and randomized back-pressured frames against a frame-level model.
module tb_dataframe_parser;
  import dataframe_parser_pkg::*;

  localparam logic [7:0] CH = 8'h3C;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] MAX_TRIGGER_LENGTH = 16'd0;
  logic        SET_CONFIG = 1'b0;
  logic        CLEAR_ERROR = 1'b0;
  logic        HDR_VALID;
  logic [47:0] HDR_TIMESTAMP;
  logic [15:0] HDR_TRIGGER_INFO;
  logic [15:0] HDR_LENGTH;
  logic        FRAME_DONE;
  logic        FRAME_OK;
  logic [4:0]  ERROR_FLAGS;
  logic [15:0] GOOD_FRAME_CNT;
  logic [15:0] BAD_FRAME_CNT;

  dataframe_parser_if sIf();
  dataframe_parser_if mIf();

  always #5 ACLK = ~ACLK;

  dataframe_parser #(.CHANNEL_ID(CH)) dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .MAX_TRIGGER_LENGTH (MAX_TRIGGER_LENGTH),
    .SET_CONFIG         (SET_CONFIG),
    .S_AXIS             (sIf),
    .M_AXIS             (mIf),
    .HDR_VALID          (HDR_VALID),
    .HDR_TIMESTAMP      (HDR_TIMESTAMP),
    .HDR_TRIGGER_INFO   (HDR_TRIGGER_INFO),
    .HDR_LENGTH         (HDR_LENGTH),
    .FRAME_DONE         (FRAME_DONE),
    .FRAME_OK           (FRAME_OK),
    .ERROR_FLAGS        (ERROR_FLAGS),
    .CLEAR_ERROR        (CLEAR_ERROR),
    .GOOD_FRAME_CNT     (GOOD_FRAME_CNT),
    .BAD_FRAME_CNT      (BAD_FRAME_CNT)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [7:0]  hdrId;
    logic [7:0]  hdrCh;
    logic [15:0] n;
    bit          hdrLast;
    int          nData;
    bit          dataLast;
    bit          sendFtr;
    logic [7:0]  ftrId;
    logic [15:0] echo;
    bit          ftrLast;
    int          tail;
    logic [47:0] ts;
    logic [15:0] trig;
    int          expFwd;
    bit          expHdr;
    bit          expOk;
    logic [4:0]  expErr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          doneSeen = 0;
  int          hdrSeen = 0;
  logic        lastOk = 1'b0;
  bit          monitorOn = 1'b0;
  bit          randReady = 1'b0;
  beat_t       expQ[$];
  logic [15:0] modelGood = 16'd0;
  logic [15:0] modelBad = 16'd0;
  logic [4:0]  modelErr = 5'd0;
  vec_t        vecs[14];

  task automatic checkOutput(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Output-side ready: always 1, or a coin flip per cycle during the random phase.
  always @(posedge ACLK) begin
    #1;
    mIf.TREADY = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESET) begin
      if (FRAME_DONE) begin
        doneSeen++;
        lastOk = FRAME_OK;
      end
      if (HDR_VALID) hdrSeen++;
      if (monitorOn && mIf.TVALID && mIf.TREADY) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 128'd1, 128'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("beatData", mIf.TDATA, e.data);
          checkOutput("beatLast", {127'd0, mIf.TLAST}, {127'd0, e.last});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mkVec(input logic [7:0] hdrId, input logic [7:0] hdrCh,
                                 input logic [15:0] n, input bit hdrLast,
                                 input int nData, input bit dataLast,
                                 input bit sendFtr, input logic [7:0] ftrId,
                                 input logic [15:0] echo, input bit ftrLast, input int tail,
                                 input int expFwd, input bit expHdr, input bit expOk,
                                 input logic [4:0] expErr);
    vec_t v;
    logic [63:0] r;
    r = {$urandom, $urandom};
    v.hdrId = hdrId;  v.hdrCh = hdrCh;  v.n = n;  v.hdrLast = hdrLast;
    v.nData = nData;  v.dataLast = dataLast;
    v.sendFtr = sendFtr;  v.ftrId = ftrId;  v.echo = echo;  v.ftrLast = ftrLast;
    v.tail = tail;  v.ts = r[47:0];  v.trig = r[63:48];
    v.expFwd = expFwd;  v.expHdr = expHdr;  v.expOk = expOk;  v.expErr = expErr;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat's handshake edge.
  task automatic sendBeat(input logic [127:0] d, input logic l);
    int waitCnt;
    bit rdy;
    waitCnt = 0;
    sIf.TDATA  = d;
    sIf.TLAST  = l;
    sIf.TVALID = 1'b1;
    do begin
      @(negedge ACLK);
      rdy = sIf.TREADY;
      @(posedge ACLK);
      waitCnt++;
    end while (!rdy && waitCnt < 1000);
    if (!rdy) checkOutput("sendTimeout", 128'd0, 128'd1);
    #1;
    sIf.TVALID = 1'b0;
    sIf.TLAST  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [127:0] d;
    beat_t b;
    sendBeat({v.hdrId, v.hdrCh, v.ts, v.trig, 32'h0, v.n}, v.hdrLast);
    for (int i = 1; i <= v.nData; i++) begin
      d = rnd128();
      if (i <= v.expFwd) begin
        b.data = d;
        b.last = (i == v.expFwd);
        expQ.push_back(b);
      end
      sendBeat(d, v.dataLast && (i == v.nData));
    end
    if (v.sendFtr) sendBeat({v.ftrId, CH, 96'h0, v.echo}, v.ftrLast);
    for (int i = 1; i <= v.tail; i++) sendBeat(rnd128(), i == v.tail);
  endtask

  task automatic waitDone(input int d0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge ACLK);
      if (doneSeen > d0 && expQ.size() == 0) break;
    end
    checkOutput("fwdPending", expQ.size(), 0);
    expQ.delete();
    @(posedge ACLK);
    #1;
  endtask

  task automatic countFrame(input bit ok);
    if (ok) modelGood = modelGood + 16'd1;
    else if (modelBad != 16'hFFFF) modelBad = modelBad + 16'd1;
  endtask

  task automatic runVec(input string nm, input vec_t v);
    int d0;
    int h0;
    d0 = doneSeen;
    h0 = hdrSeen;
    applyStimulus(v);
    waitDone(d0);
    countFrame(v.expOk);
    checkOutput({nm, ".doneCnt"}, doneSeen - d0, 1);
    checkOutput({nm, ".frameOk"}, {127'd0, lastOk}, {127'd0, v.expOk});
    checkOutput({nm, ".hdrCnt"}, hdrSeen - h0, {127'd0, v.expHdr});
    checkOutput({nm, ".errFlags"}, ERROR_FLAGS, v.expErr);
    checkOutput({nm, ".goodCnt"}, GOOD_FRAME_CNT, modelGood);
    checkOutput({nm, ".badCnt"}, BAD_FRAME_CNT, modelBad);
    if (v.expHdr) begin
      checkOutput({nm, ".hdrLen"}, HDR_LENGTH, v.n);
      checkOutput({nm, ".hdrTs"}, HDR_TIMESTAMP, v.ts);
      checkOutput({nm, ".hdrTrig"}, HDR_TRIGGER_INFO, v.trig);
    end
  endtask

  task automatic clearErrors();
    CLEAR_ERROR = 1'b1;
    @(posedge ACLK);
    #1;
    CLEAR_ERROR = 1'b0;
    checkOutput("clearedFlags", ERROR_FLAGS, 5'd0);
  endtask

  task automatic setConfig(input logic [15:0] maxLen);
    MAX_TRIGGER_LENGTH = maxLen;
    SET_CONFIG = 1'b1;
    @(posedge ACLK);
    #1;
    SET_CONFIG = 1'b0;
  endtask

  task automatic checkAllZero(input string nm);
    checkOutput({nm, ".mValid"}, {127'd0, mIf.TVALID}, 128'd0);
    checkOutput({nm, ".mData"}, mIf.TDATA, 128'd0);
    checkOutput({nm, ".hdrValid"}, {127'd0, HDR_VALID}, 128'd0);
    checkOutput({nm, ".hdrTs"}, HDR_TIMESTAMP, 48'd0);
    checkOutput({nm, ".hdrLen"}, HDR_LENGTH, 16'd0);
    checkOutput({nm, ".frameDone"}, {127'd0, FRAME_DONE}, 128'd0);
    checkOutput({nm, ".errFlags"}, ERROR_FLAGS, 5'd0);
    checkOutput({nm, ".goodCnt"}, GOOD_FRAME_CNT, 16'd0);
    checkOutput({nm, ".badCnt"}, BAD_FRAME_CNT, 16'd0);
  endtask

  initial begin
    vec_t v;
    int d0;
    logic [15:0] n;
    bit bad;

    sIf.TVALID = 1'b0;
    sIf.TLAST  = 1'b0;
    sIf.TDATA  = '0;

    // Columns: hdrId hdrCh n hdrLast | nData dataLast | ftr ftrId echo ftrLast | tail | expFwd expHdr expOk expErr
    vecs[0]  = mkVec(8'hAA, CH,    16'd4,   0, 4,   0, 1, 8'h55, 16'd4,   1, 0, 4,   1, 1, 5'b00000);
    vecs[0].ts = 48'h00123456789A;
    vecs[1]  = mkVec(8'hAB, CH,    16'd4,   0, 0,   0, 0, 8'h55, 16'd0,   0, 5, 0,   0, 0, 5'b00001);
    vecs[2]  = mkVec(8'hAA, CH,    16'd1,   0, 1,   0, 1, 8'h55, 16'd1,   1, 0, 1,   1, 1, 5'b00000);
    vecs[3]  = mkVec(8'hAA, CH,    16'd8,   0, 5,   1, 0, 8'h55, 16'd0,   0, 0, 5,   1, 0, 5'b10000);
    vecs[4]  = mkVec(8'hAA, CH,    16'd3,   0, 3,   0, 1, 8'h55, 16'd3,   1, 0, 3,   1, 1, 5'b00000);
    vecs[5]  = mkVec(8'hAA, CH,    16'd8,   0, 8,   0, 1, 8'h55, 16'd7,   1, 0, 8,   1, 0, 5'b00100);
    vecs[6]  = mkVec(8'hAA, 8'h3D, 16'd4,   1, 0,   0, 0, 8'h55, 16'd0,   0, 0, 0,   0, 0, 5'b00001);
    vecs[7]  = mkVec(8'hAA, CH,    16'd0,   0, 0,   0, 0, 8'h55, 16'd0,   0, 2, 0,   0, 0, 5'b00010);
    vecs[8]  = mkVec(8'hAA, CH,    16'd3,   0, 3,   0, 1, 8'h56, 16'd3,   1, 0, 3,   1, 0, 5'b01000);
    vecs[9]  = mkVec(8'hAA, CH,    16'd2,   0, 2,   0, 1, 8'h55, 16'd2,   0, 1, 2,   1, 0, 5'b00100);
    vecs[10] = mkVec(8'hAA, CH,    16'd5,   1, 0,   0, 0, 8'h55, 16'd0,   0, 0, 0,   0, 0, 5'b10000);
    vecs[11] = mkVec(8'hAA, CH,    16'd512, 0, 512, 0, 1, 8'h55, 16'd512, 1, 0, 512, 1, 1, 5'b00000);
    vecs[12] = mkVec(8'hAA, CH,    16'd513, 0, 0,   0, 0, 8'h55, 16'd0,   0, 3, 0,   0, 0, 5'b00010);
    vecs[13] = mkVec(8'hAA, CH,    16'd2,   0, 2,   0, 1, 8'h57, 16'd9,   1, 0, 2,   1, 0, 5'b01100);

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset.sReady", {127'd0, sIf.TREADY}, 128'd1);
    checkAllZero("reset");
    ARESET = 1'b0;
    monitorOn = 1'b1;
    @(posedge ACLK);
    #1;

    $display("[TB] table-driven frames");
    for (int i = 0; i < 14; i++) begin
      clearErrors();
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    $display("[TB] config: max length 16");
    clearErrors();
    setConfig(16'd16);
    runVec("cfg17", mkVec(8'hAA, CH, 16'd17, 0, 0, 0, 0, 8'h55, 16'd0, 0, 2, 0, 0, 0, 5'b00010));
    runVec("cfg16", mkVec(8'hAA, CH, 16'd16, 0, 16, 0, 1, 8'h55, 16'd16, 1, 0, 16, 1, 1, 5'b00010));
    setConfig(16'd512);

    $display("[TB] clear and new error in the same cycle");
    d0 = doneSeen;
    CLEAR_ERROR = 1'b1;
    sendBeat({8'hAB, CH, 48'h0, 16'h0, 32'h0, 16'd4}, 1'b1);
    CLEAR_ERROR = 1'b0;
    waitDone(d0);
    countFrame(1'b0);
    checkOutput("clrVsErr.flags", ERROR_FLAGS, 5'b00001);
    checkOutput("clrVsErr.badCnt", BAD_FRAME_CNT, modelBad);

    $display("[TB] reset in the middle of DATA");
    monitorOn = 1'b0;
    d0 = doneSeen;
    sendBeat({8'hAA, CH, 48'h1, 16'h2, 32'h0, 16'd10}, 1'b0);
    for (int i = 0; i < 3; i++) sendBeat(rnd128(), 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    checkAllZero("midReset");
    ARESET = 1'b0;
    modelGood = 16'd0;
    modelBad = 16'd0;
    expQ.delete();
    @(posedge ACLK);
    #1;
    checkOutput("midReset.noDone", doneSeen - d0, 0);
    monitorOn = 1'b1;
    runVec("afterReset", mkVec(8'hAA, CH, 16'd6, 0, 6, 0, 1, 8'h55, 16'd6, 1, 0, 6, 1, 1, 5'b00000));

    $display("[TB] randomized frames with output back-pressure");
    clearErrors();
    modelErr = 5'd0;
    randReady = 1'b1;
    for (int f = 0; f < 60; f++) begin
      n = 16'($urandom_range(1, 512));
      bad = ($urandom_range(0, 5) == 0);
      if (bad) modelErr[ERR_LEN_MISMATCH] = 1'b1;
      v = mkVec(8'hAA, CH, n, 0, int'(n), 0, 1, 8'h55, bad ? (n ^ 16'h0001) : n, 1, 0,
                int'(n), 1, !bad, modelErr);
      runVec($sformatf("rnd%0d", f), v);
    end
    randReady = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
